if_inst_queue: RTL and testbench

IF_INST_QUEUE -- requirements
Module: if_inst_queue

---
 rtl/if_inst_queue_pkg.sv | 29 ++
 rtl/if_queue_fifo.sv | 102 ++++++++++
 rtl/if_inst_queue.sv | 134 +++++++++++++
 tb/tb_if_inst_queue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_inst_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_inst_queue_pkg
//  Description : Shared core types for the instruction-fetch queue: address
//                and data widths, exception bit positions, queue entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_inst_queue_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    // Bit positions inside the 4-bit exception vector {ppi,pif,tlbr,adef}
    localparam int EXC_ADEF = 0;
    localparam int EXC_TLBR = 1;
    localparam int EXC_PIF  = 2;
    localparam int EXC_PPI  = 3;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic                  branch;
        logic [ADDR_WIDTH-1:0] branch_addr;
        logic [DATA_WIDTH-1:0] inst;
        logic                  adef;
        logic                  filled;
    } iq_entry_t;

endpackage : if_inst_queue_pkg
`default_nettype wire

// File: rtl/if_queue_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : if_queue_fifo
//  Description : Circular entry store for the fetch queue. Entries are
//                allocated at the tail, filled out of band (oldest unfilled
//                first) and popped from the head in allocation order.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_queue_fifo
    import if_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  iq_entry_t             push_entry_i,
    input  logic                  fill_i,
    input  logic [DATA_WIDTH-1:0] fill_data_i,
    input  logic                  pop_i,
    output iq_entry_t             head_o,
    output logic                  full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = 1;
    localparam logic [PTR_W-1:0] c_PTR_ONE = 1;

    iq_entry_t              mem_q [DEPTH];
    logic [DEPTH-1:0]       filled_q;
    logic [PTR_W-1:0]       head_q, tail_q;
    logic [CNT_W-1:0]       count_q;
    logic                   fill_hit;
    logic [PTR_W-1:0]       fill_idx;

    assign full_o = (count_q == CNT_W'(DEPTH));

    // Locate the oldest allocated entry still waiting for its word; words
    // come back in request order, so this is always the right target.
    always_comb begin
        fill_hit = 1'b0;
        fill_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!fill_hit && (i < int'(count_q)) && !filled_q[head_q + PTR_W'(i)]) begin
                fill_hit = 1'b1;
                fill_idx = head_q + PTR_W'(i);
            end
        end
    end

    // Head view: storage payload with the live filled flag substituted in.
    always_comb begin
        head_o        = mem_q[head_q];
        head_o.filled = filled_q[head_q];
    end

    // Pointer, occupancy and filled-flag bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            filled_q <= '0;
        end else if (flush_i) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            filled_q <= '0;
        end else begin
            if (push_i) begin
                tail_q           <= tail_q + c_PTR_ONE;
                filled_q[tail_q] <= push_entry_i.filled;
            end
            if (fill_i && fill_hit) begin
                filled_q[fill_idx] <= 1'b1;
            end
            if (pop_i) begin
                head_q           <= head_q + c_PTR_ONE;
                filled_q[head_q] <= 1'b0;
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + c_CNT_ONE;
            end else if (!push_i && pop_i) begin
                count_q <= count_q - c_CNT_ONE;
            end
        end
    end

    // Entry payload storage; validity is carried by filled_q, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[tail_q] <= push_entry_i;
        end
        if (fill_i && fill_hit) begin
            mem_q[fill_idx].inst <= fill_data_i;
        end
    end

endmodule : if_queue_fifo
`default_nettype wire

// File: rtl/if_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_inst_queue
//  Description : Instruction-fetch queue. Issues instruction-SRAM requests
//                for offered PCs, parks them in order, fills them as words
//                return and hands completed entries to decode. Redirects
//                drop queued entries and discard words still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_inst_queue
    import if_inst_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic                  in_branch,
    input  logic [ADDR_WIDTH-1:0] in_branch_addr,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  inst_req,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_addr_ok,
    input  logic                  inst_data_ok,
    input  logic [DATA_WIDTH-1:0] inst_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic                  out_branch,
    output logic [ADDR_WIDTH-1:0] out_branch_addr,
    output logic [3:0]            out_except_type
);

    localparam int OC_W = $clog2(MAX_OUTST + 1);
    localparam logic [OC_W-1:0] c_OC_ONE = 1;

    logic [OC_W-1:0] outst_q, outst_d;
    logic [OC_W-1:0] discard_q, discard_d;
    logic            w_aligned;
    logic            w_slot_free;
    logic            w_push;
    logic            w_req_acc;
    logic            w_fill;
    logic            w_pop;
    logic            w_full;
    iq_entry_t       w_push_entry;
    iq_entry_t       w_head;

    assign w_aligned   = (in_pc[1:0] == 2'b00);
    assign w_slot_free = !w_full;

    // rst gating keeps the handshakes quiet while reset is held.
    assign inst_req  = rst && in_valid && w_aligned && !flush && w_slot_free
                       && (outst_q < OC_W'(MAX_OUTST));
    assign inst_addr = in_pc;
    assign in_ready  = w_aligned ? (inst_req && inst_addr_ok)
                                 : (rst && w_slot_free && !flush);

    assign w_push    = in_valid && in_ready;
    assign w_req_acc = w_push && w_aligned;
    assign w_fill    = inst_data_ok && (discard_q == '0) && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    // Misaligned PCs are complete on arrival: no fetch, zero word, adef set.
    always_comb begin
        w_push_entry             = '0;
        w_push_entry.pc          = in_pc;
        w_push_entry.branch      = in_branch;
        w_push_entry.branch_addr = in_branch_addr;
        w_push_entry.adef        = !w_aligned;
        w_push_entry.filled      = !w_aligned;
    end

    if_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (rst),
        .flush_i      (flush),
        .push_i       (w_push),
        .push_entry_i (w_push_entry),
        .fill_i       (w_fill),
        .fill_data_i  (inst_rdata),
        .pop_i        (w_pop),
        .head_o       (w_head),
        .full_o       (w_full)
    );

    assign out_valid       = w_head.filled;
    assign out_pc          = w_head.pc;
    assign out_inst        = w_head.inst;
    assign out_branch      = w_head.branch;
    assign out_branch_addr = w_head.branch_addr;

    // Exception vector; only adef can be raised by this stage.
    always_comb begin
        out_except_type           = 4'b0000;
        out_except_type[EXC_ADEF] = out_valid && w_head.adef;
    end

    // Outstanding-request and discard counter next-state.
    always_comb begin
        outst_d   = outst_q;
        discard_d = discard_q;
        if (w_req_acc && !inst_data_ok) begin
            outst_d = outst_q + c_OC_ONE;
        end else if (!w_req_acc && inst_data_ok) begin
            outst_d = outst_q - c_OC_ONE;
        end
        if (flush) begin
            // Everything still in flight after this cycle belongs to killed PCs.
            discard_d = inst_data_ok ? (outst_q - c_OC_ONE) : outst_q;
        end else if (inst_data_ok && (discard_q != '0)) begin
            discard_d = discard_q - c_OC_ONE;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

endmodule : if_inst_queue
`default_nettype wire

// File: tb/tb_if_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_inst_queue
//  Description : Directed self-checking bench for if_inst_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic        in_branch;
    logic [31:0] in_branch_addr;
    logic        in_ready;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_branch;
    logic [31:0] out_branch_addr;
    logic [3:0]  out_except_type;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    if_inst_queue #(
        .DEPTH     (4),
        .MAX_OUTST (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_pc           (in_pc),
        .in_branch       (in_branch),
        .in_branch_addr  (in_branch_addr),
        .in_ready        (in_ready),
        .flush           (flush),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .out_branch      (out_branch),
        .out_branch_addr (out_branch_addr),
        .out_except_type (out_except_type)
    );

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        in_branch    = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        in_valid = 1'b1; in_pc = 32'h1C00_0000; inst_addr_ok = 1'b1;
        #1;
        vec_cnt++; if (inst_req !== 1'b0) begin err_cnt++; $display("FAIL rst_inst_req got %b want 0", inst_req); end
        vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        vec_cnt++; if (out_except_type !== 4'b0) begin err_cnt++; $display("FAIL rst_except got %h want 0", out_except_type); end
        cyc(); cyc();
        idle(); rst = 1'b1;
        cyc();
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL post_rst_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_basic();
        cyc();
        in_valid = 1'b1; in_pc = 32'h1C00_0000; in_branch = 1'b1;
        in_branch_addr = 32'h1C00_0040; inst_addr_ok = 1'b1; out_ready = 1'b1;
        #1;
        vec_cnt++; if (inst_req !== 1'b1) begin err_cnt++; $display("FAIL basic_req got %b want 1", inst_req); end
        vec_cnt++; if (inst_addr !== 32'h1C00_0000) begin err_cnt++; $display("FAIL basic_addr got %h want 1c000000", inst_addr); end
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL basic_ready got %b want 1", in_ready); end
        cyc();
        idle(); inst_data_ok = 1'b1; inst_rdata = 32'h0280_0000;
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_no_bypass got %b want 0", out_valid); end
        cyc();
        idle();
        #1;
        vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_valid got %b want 1", out_valid); end
        vec_cnt++; if (out_pc !== 32'h1C00_0000) begin err_cnt++; $display("FAIL basic_pc got %h want 1c000000", out_pc); end
        vec_cnt++; if (out_inst !== 32'h0280_0000) begin err_cnt++; $display("FAIL basic_inst got %h want 02800000", out_inst); end
        vec_cnt++; if (out_except_type !== 4'b0) begin err_cnt++; $display("FAIL basic_except got %h want 0", out_except_type); end
        vec_cnt++; if (out_branch !== 1'b1) begin err_cnt++; $display("FAIL basic_branch got %b want 1", out_branch); end
        vec_cnt++; if (out_branch_addr !== 32'h1C00_0040) begin err_cnt++; $display("FAIL basic_baddr got %h want 1c000040", out_branch_addr); end
        cyc();
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_popped got %b want 0", out_valid); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            idle();
            in_valid = 1'b1; in_pc = 32'h1C00_0100 + 32'(4 * k); inst_addr_ok = 1'b1;
            inst_data_ok = (k >= 1) && (k <= 4);
            inst_rdata = 32'hD000_0000 + 32'(k - 1);
            #1;
            vec_cnt++; if (in_ready !== (k < 4)) begin err_cnt++; $display("FAIL full_ready[%0d] got %b want %b", k, in_ready, (k < 4)); end
        end
        cyc();
        idle();
        for (int i = 0; i < 4; i++) begin
            cyc();
            out_ready = 1'b1;
            #1;
            vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL full_valid[%0d] got %b want 1", i, out_valid); end
            vec_cnt++; if (out_pc !== 32'h1C00_0100 + 32'(4 * i)) begin err_cnt++; $display("FAIL full_pc[%0d] got %h want %h", i, out_pc, 32'h1C00_0100 + 32'(4 * i)); end
            vec_cnt++; if (out_inst !== 32'hD000_0000 + 32'(i)) begin err_cnt++; $display("FAIL full_inst[%0d] got %h want %h", i, out_inst, 32'hD000_0000 + 32'(i)); end
        end
        cyc();
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL full_empty got %b want 0", out_valid); end
    endtask

    task automatic test_outst();
        out_ready = 1'b1;
        cyc(); idle(); in_valid = 1'b1; in_pc = 32'h1C00_0200; inst_addr_ok = 1'b1;
        cyc(); in_pc = 32'h1C00_0204;
        cyc(); in_pc = 32'h1C00_0208;
        #1;
        vec_cnt++; if (inst_req !== 1'b0) begin err_cnt++; $display("FAIL outst_req_a got %b want 0", inst_req); end
        vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL outst_ready_a got %b want 0", in_ready); end
        cyc();
        #1;
        vec_cnt++; if (inst_req !== 1'b0) begin err_cnt++; $display("FAIL outst_req_b got %b want 0", inst_req); end
        cyc(); inst_data_ok = 1'b1; inst_rdata = 32'hA000_0000;
        #1;
        vec_cnt++; if (inst_req !== 1'b0) begin err_cnt++; $display("FAIL outst_req_c got %b want 0", inst_req); end
        cyc(); inst_data_ok = 1'b0;
        #1;
        vec_cnt++; if (inst_req !== 1'b1) begin err_cnt++; $display("FAIL outst_req_d got %b want 1", inst_req); end
        vec_cnt++; if (out_pc !== 32'h1C00_0200 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL outst_pc0 got %h/%b want 1c000200/1", out_pc, out_valid); end
        vec_cnt++; if (out_inst !== 32'hA000_0000) begin err_cnt++; $display("FAIL outst_inst0 got %h want a0000000", out_inst); end
        cyc(); idle(); inst_data_ok = 1'b1; inst_rdata = 32'hA000_0001;
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL outst_gap got %b want 0", out_valid); end
        cyc(); inst_rdata = 32'hA000_0002;
        #1;
        vec_cnt++; if (out_pc !== 32'h1C00_0204 || out_inst !== 32'hA000_0001) begin err_cnt++; $display("FAIL outst_e1 got %h/%h want 1c000204/a0000001", out_pc, out_inst); end
        cyc(); idle();
        #1;
        vec_cnt++; if (out_pc !== 32'h1C00_0208 || out_inst !== 32'hA000_0002 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL outst_e2 got %h/%h/%b want 1c000208/a0000002/1", out_pc, out_inst, out_valid); end
        cyc();
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL outst_empty got %b want 0", out_valid); end
    endtask

    task automatic test_misaligned();
        out_ready = 1'b0;
        cyc(); idle(); in_valid = 1'b1; in_pc = 32'h1C00_0002; inst_addr_ok = 1'b1;
        #1;
        vec_cnt++; if (inst_req !== 1'b0) begin err_cnt++; $display("FAIL mis_req got %b want 0", inst_req); end
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL mis_ready got %b want 1", in_ready); end
        cyc(); idle(); out_ready = 1'b1;
        #1;
        vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL mis_valid got %b want 1", out_valid); end
        vec_cnt++; if (out_except_type !== 4'b0001) begin err_cnt++; $display("FAIL mis_except got %b want 0001", out_except_type); end
        vec_cnt++; if (out_inst !== 32'h0) begin err_cnt++; $display("FAIL mis_inst got %h want 0", out_inst); end
        vec_cnt++; if (out_pc !== 32'h1C00_0002) begin err_cnt++; $display("FAIL mis_pc got %h want 1c000002", out_pc); end
        cyc();
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL mis_popped got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        cyc(); idle(); in_valid = 1'b1; in_pc = 32'h1C00_0300; inst_addr_ok = 1'b1;
        cyc(); in_pc = 32'h1C00_0304;
        cyc(); in_pc = 32'h1C00_1000; flush = 1'b1;
        #1;
        vec_cnt++; if (in_ready !== 1'b0 || inst_req !== 1'b0) begin err_cnt++; $display("FAIL fl_block got %b/%b want 0/0", in_ready, inst_req); end
        cyc(); flush = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hBAD0_0000;
        #1;
        vec_cnt++; if (inst_req !== 1'b0) begin err_cnt++; $display("FAIL fl_limit got %b want 0", inst_req); end
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL fl_valid_a got %b want 0", out_valid); end
        cyc(); inst_rdata = 32'hBAD0_0001;
        #1;
        vec_cnt++; if (inst_req !== 1'b1) begin err_cnt++; $display("FAIL fl_req got %b want 1", inst_req); end
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL fl_valid_b got %b want 0", out_valid); end
        cyc(); idle(); inst_data_ok = 1'b1; inst_rdata = 32'hC0DE_0001;
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL fl_valid_c got %b want 0", out_valid); end
        cyc(); idle();
        #1;
        vec_cnt++; if (out_valid !== 1'b1 || out_pc !== 32'h1C00_1000) begin err_cnt++; $display("FAIL fl_pc got %b/%h want 1/1c001000", out_valid, out_pc); end
        vec_cnt++; if (out_inst !== 32'hC0DE_0001) begin err_cnt++; $display("FAIL fl_inst got %h want c0de0001", out_inst); end
        cyc();
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL fl_empty got %b want 0", out_valid); end
    endtask

    task automatic test_flush_dataok();
        out_ready = 1'b1;
        cyc(); idle(); in_valid = 1'b1; in_pc = 32'h1C00_0400; inst_addr_ok = 1'b1;
        cyc(); idle(); flush = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hBAD0_0002;
        cyc(); idle(); in_valid = 1'b1; in_pc = 32'h1C00_2000; inst_addr_ok = 1'b1;
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL fd_stale got %b want 0", out_valid); end
        vec_cnt++; if (inst_req !== 1'b1) begin err_cnt++; $display("FAIL fd_req got %b want 1", inst_req); end
        cyc(); idle(); inst_data_ok = 1'b1; inst_rdata = 32'hC0DE_0002;
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL fd_early got %b want 0", out_valid); end
        cyc(); idle();
        #1;
        vec_cnt++; if (out_valid !== 1'b1 || out_pc !== 32'h1C00_2000) begin err_cnt++; $display("FAIL fd_pc got %b/%h want 1/1c002000", out_valid, out_pc); end
        vec_cnt++; if (out_inst !== 32'hC0DE_0002) begin err_cnt++; $display("FAIL fd_inst got %h want c0de0002", out_inst); end
        cyc();
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL fd_empty got %b want 0", out_valid); end
    endtask

    initial begin
        rst            = 1'b0;
        in_pc          = '0;
        in_branch_addr = '0;
        inst_rdata     = '0;
        out_ready      = 1'b0;
        idle();
        test_reset();
        test_basic();
        test_full();
        test_outst();
        test_misaligned();
        test_flush();
        test_flush_dataok();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_if_inst_queue
`default_nettype wire
